// File: rtl/note_pkg.sv
// note_pkg: shared constants and the (freq_id1, freq_id2) pair type for the note interface
package note_pkg;
    localparam int NUM_KEYS = 25;
    localparam int FREQ_ID_W = 5;
    localparam int RUN_W = 4;
    localparam logic [FREQ_ID_W-1:0] NO_FREQ = 5'd31;
    typedef struct packed {
        logic [FREQ_ID_W-1:0] f1;
        logic [FREQ_ID_W-1:0] f2;
    } pair_t;
    localparam pair_t NO_PAIR = '{f1: NO_FREQ, f2: NO_FREQ};
endpackage

// File: rtl/note_chord_encoder_if.sv
// note_chord_encoder_if: note interface between the chord encoder (master) and the physics block (slave)
//   wave_ready : slave -> master, downstream can accept a new pair
//   freq_id1/2 : master -> slave, committed pair (31 = none)
//   new_f_out  : master -> slave, one-frame strobe on pair change
//   pending    : master -> slave, a stable pair is waiting for wave_ready
interface note_chord_encoder_if;
    import note_pkg::*;
    logic                 wave_ready;
    logic [FREQ_ID_W-1:0] freq_id1;
    logic [FREQ_ID_W-1:0] freq_id2;
    logic                 new_f_out;
    logic                 pending;
    modport master (input wave_ready, output freq_id1, freq_id2, new_f_out, pending);
    modport slave (output wave_ready, input freq_id1, freq_id2, new_f_out, pending);
endinterface

// File: rtl/note_prio_enc.sv
// note_prio_enc: lowest/highest set key index of a key vector
//   keys_i  : key vector
//   lo_o    : index of lowest set bit (0 when none)
//   hi_o    : index of highest set bit (0 when none)
//   any_o   : at least one key set
//   multi_o : at least two keys set
module note_prio_enc
    import note_pkg::*;
(
    input  logic [NUM_KEYS-1:0]  keys_i,
    output logic [FREQ_ID_W-1:0] lo_o,
    output logic [FREQ_ID_W-1:0] hi_o,
    output logic                 any_o,
    output logic                 multi_o
);
    always_comb begin
        lo_o = '0;
        hi_o = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (keys_i[i]) lo_o = i[FREQ_ID_W-1:0];
        for (int i = 0; i < NUM_KEYS; i++)
            if (keys_i[i]) hi_o = i[FREQ_ID_W-1:0];
    end

    assign any_o = |keys_i;
    // lowest and highest differ exactly when two or more keys are set
    assign multi_o = any_o & (lo_o != hi_o);
endmodule

// File: rtl/note_chord_encoder.sv
// note_chord_encoder: debounces keyboard notes per frame and emits a two-note pair with handshake
//   clock    : system pixel clock
//   reset    : synchronous, active-high
//   vsync    : frame sync; falling edge is the frame tick
//   key_down : per-key level, 1 = pressed
//   nt       : note interface (master side)
module note_chord_encoder
    import note_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                vsync,
    input  logic [NUM_KEYS-1:0] key_down,
    note_chord_encoder_if.master nt
);
    localparam logic [RUN_W-1:0] DB = RUN_W'(DEBOUNCE_FRAMES);

    logic                 vsync_q;
    logic [RUN_W-1:0]     run_q, run_d;
    logic [NUM_KEYS-1:0]  prev_q, prev_d;
    pair_t                out_q, out_d;
    pair_t                pend_pair_q, pend_pair_d;
    logic                 new_f_q, new_f_d;
    logic                 pending_q, pending_d;
    logic                 tick;
    logic [FREQ_ID_W-1:0] lo, hi;
    logic                 any, multi;
    pair_t                cand;

    note_prio_enc u_enc (
        .keys_i  (key_down),
        .lo_o    (lo),
        .hi_o    (hi),
        .any_o   (any),
        .multi_o (multi)
    );

    assign tick = vsync_q & ~vsync;
    assign cand = '{f1: any ? lo : NO_FREQ, f2: multi ? hi : NO_FREQ};

    always_comb begin
        run_d = run_q;
        prev_d = prev_q;
        out_d = out_q;
        pend_pair_d = pend_pair_q;
        new_f_d = new_f_q;
        pending_d = pending_q;
        if (tick) begin
            prev_d = key_down;
            run_d = (key_down == prev_q) ? ((run_q == DB) ? run_q : run_q + 1'b1) : RUN_W'(1);
            if (new_f_q) begin
                new_f_d = 1'b0;
            end else if (pending_q && nt.wave_ready) begin
                out_d = pend_pair_q;
                new_f_d = 1'b1;
                pending_d = 1'b0;
            end
            // a commit in the same tick overrides the emission's pending clear;
            // the comparison is against the pair that was on the outputs before this tick
            if (run_d == DB) begin
                if (cand != out_q) begin
                    pend_pair_d = cand;
                    pending_d = 1'b1;
                end else begin
                    pending_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vsync_q <= 1'b0;
            run_q <= '0;
            prev_q <= '0;
            out_q <= NO_PAIR;
            pend_pair_q <= NO_PAIR;
            new_f_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            vsync_q <= vsync;
            run_q <= run_d;
            prev_q <= prev_d;
            out_q <= out_d;
            pend_pair_q <= pend_pair_d;
            new_f_q <= new_f_d;
            pending_q <= pending_d;
        end
    end

    assign nt.freq_id1 = out_q.f1;
    assign nt.freq_id2 = out_q.f2;
    assign nt.new_f_out = new_f_q;
    assign nt.pending = pending_q;
endmodule

// File: tb/tb_note_chord_encoder.sv
// tb_note_chord_encoder: randomized and directed scoreboard bench for note_chord_encoder
module tb_note_chord_encoder;
    localparam int DB = 3;
    localparam int NK = 25;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          vsync = 1'b0;
    logic [NK-1:0] key_down = '0;

    note_chord_encoder_if nt();

    note_chord_encoder #(.DEBOUNCE_FRAMES(DB)) dut (
        .clock    (clock),
        .reset    (reset),
        .vsync    (vsync),
        .key_down (key_down),
        .nt       (nt)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;

    logic [9:0]    exp_q[$];
    logic [NK-1:0] hist[$];
    int            m_f1, m_f2, m_pp1, m_pp2;
    bit            m_newf, m_pend;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_f1 = 31; m_f2 = 31; m_pp1 = 31; m_pp2 = 31;
        m_newf = 0; m_pend = 0;
    endtask

    // one frame of the reference: stable = last DB samples since reset all identical
    task automatic model_step(input logic [NK-1:0] keys, input bit wr);
        int  lo, hi, cnt, o1, o2;
        bit  stable, nf, pd;
        lo = 31; hi = 31; cnt = 0;
        for (int i = 0; i < NK; i++)
            if (keys[i]) begin
                if (cnt == 0) lo = i;
                hi = i;
                cnt++;
            end
        if (cnt < 2) hi = 31;
        hist.push_back(keys);
        if (hist.size() > DB) void'(hist.pop_front());
        stable = (hist.size() == DB);
        foreach (hist[i]) if (hist[i] != keys) stable = 0;
        o1 = m_f1; o2 = m_f2; nf = m_newf; pd = m_pend;
        if (nf) m_newf = 0;
        else if (pd && wr) begin
            m_f1 = m_pp1; m_f2 = m_pp2; m_newf = 1; m_pend = 0;
            exp_q.push_back({5'(m_f1), 5'(m_f2)});
        end
        if (stable) begin
            if (lo != o1 || hi != o2) begin
                m_pp1 = lo; m_pp2 = hi; m_pend = 1;
            end else m_pend = 0;
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_f1"}, int'(nt.freq_id1), m_f1);
        chk({tag, "_f2"}, int'(nt.freq_id2), m_f2);
        chk({tag, "_newf"}, int'(nt.new_f_out), int'(m_newf));
        chk({tag, "_pend"}, int'(nt.pending), int'(m_pend));
    endtask

    // between ticks key_down and wave_ready carry junk; only the values at the tick matter
    task automatic do_frame(input logic [NK-1:0] keys, input bit wr);
        @(negedge clock);
        vsync = 1'b1;
        key_down = NK'($urandom);
        nt.wave_ready = 1'($urandom);
        @(negedge clock);
        key_down = NK'($urandom);
        nt.wave_ready = 1'($urandom);
        @(negedge clock);
        key_down = keys;
        nt.wave_ready = wr;
        vsync = 1'b0;
        @(posedge clock);
        model_step(keys, wr);
        @(negedge clock);
        chk_state("frame");
    endtask

    task automatic do_reset(input int cycles, input int half);
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            vsync = ((c / half) % 2) == 0;
            key_down = NK'($urandom);
            nt.wave_ready = 1'($urandom);
            @(negedge clock);
            chk("rst_f1", int'(nt.freq_id1), 31);
            chk("rst_f2", int'(nt.freq_id2), 31);
            chk("rst_newf", int'(nt.new_f_out), 0);
            chk("rst_pend", int'(nt.pending), 0);
        end
        vsync = 1'b0;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic hold(input logic [NK-1:0] keys, input bit wr, input int n);
        for (int i = 0; i < n; i++) do_frame(keys, wr);
    endtask

    logic prev_newf = 1'b0;
    always @(negedge clock) begin
        if (!reset && nt.new_f_out && !prev_newf) begin
            if (exp_q.size() == 0) chk("sb_unexpected_pulse", 1, 0);
            else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                chk("sb_f1", int'(nt.freq_id1), int'(e[9:5]));
                chk("sb_f2", int'(nt.freq_id2), int'(e[4:0]));
            end
        end
        prev_newf <= nt.new_f_out;
    end

    initial begin
        logic [NK-1:0] cur;
        nt.wave_ready = 1'b0;
        model_reset();
        do_reset(250, 50);

        hold(25'(1) << 7, 1'b1, 6);

        do_reset(4, 2);
        for (int i = 0; i < 12; i++) do_frame((i % 2) ? 25'(1) << 7 : 25'(0), 1'b1);

        do_reset(4, 2);
        hold((25'(1) << 3) | (25'(1) << 12) | (25'(1) << 20), 1'b1, 6);
        hold((25'(1) << 2) | (25'(1) << 3) | (25'(1) << 12) | (25'(1) << 20), 1'b1, 6);

        do_reset(4, 2);
        hold(25'(1) << 7, 1'b1, 6);
        hold(25'(1) << 5, 1'b0, 5);
        hold(25'(1) << 5, 1'b1, 4);

        do_reset(4, 2);
        hold(25'(1) << 7, 1'b1, 6);
        hold(25'(1) << 9, 1'b0, 4);
        hold(25'(1) << 7, 1'b0, 4);
        hold(25'(1) << 7, 1'b1, 4);

        hold({NK{1'b1}}, 1'b1, 4);
        hold('0, 1'b1, 5);

        do_reset(4, 2);
        hold(25'(1) << 11, 1'b1, 4);
        do_reset(2, 1);

        cur = '0;
        for (int f = 0; f < 60; f++) begin
            case ($urandom_range(0, 5))
                0: cur = '0;
                1: cur = {NK{1'b1}};
                2: cur = 25'(1) << $urandom_range(0, NK - 1);
                3: cur = (25'(1) << $urandom_range(0, NK - 1)) | (25'(1) << $urandom_range(0, NK - 1));
                4: cur = NK'($urandom);
                default: ;
            endcase
            for (int r = $urandom_range(1, 5); r > 0; r--) do_frame(cur, $urandom_range(0, 3) != 0);
        end

        repeat (4) @(negedge clock);
        chk("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
